// File: rtl/bip_pkg.sv
// Shared BIP definitions: instruction field widths, opcode constants, loader states and error codes.
// Used by the program loader and the instruction decoder.
package bip_pkg;

  localparam int NB_OPCODE  = 5;
  localparam int NB_OPERAND = 11;
  localparam int NB_INSTR   = NB_OPCODE + NB_OPERAND;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'd0;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'd1;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'd2;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'd3;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'd4;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'd5;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'd6;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'd7;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE,
    ST_ERROR,
    ST_CHECK
  } loader_state_e;

  // The instruction set is dense from HLT up to SUBI.
  function automatic logic opcode_valid(input logic [NB_OPCODE-1:0] op);
    return op <= OP_SUBI;
  endfunction

endpackage

// File: rtl/bip_prog_loader.sv
// BIP program loader: assembles UART bytes into 16-bit instructions and writes them to program RAM.
// Optional macro BIP_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before the CPU runs.
module bip_prog_loader
  import bip_pkg::*;
#(
  parameter int NB_BYTE    = 8,
  parameter int NB_ADDR    = 11,
  parameter int PROG_DEPTH = 2048
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_done,
  input  logic                i_restart,
  output logic                o_wr_en,
  output logic [NB_ADDR-1:0]  o_wr_addr,
  output logic [NB_INSTR-1:0] o_wr_data,
  output logic                o_cpu_enable,
  output logic                o_done,
  output logic                o_error,
  output logic [1:0]          o_error_code
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(PROG_DEPTH - 1);

  loader_state_e       state_q;
  logic [NB_ADDR-1:0]  addr_q;
  logic [NB_BYTE-1:0]  hi_q;
  logic                wr_en_q;
  logic [NB_ADDR-1:0]  wr_addr_q;
  logic [NB_INSTR-1:0] wr_data_q;
  logic                done_q;
  logic                cpu_en_q;
  logic                error_q;
  logic [1:0]          code_q;
`ifdef BIP_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0]  csum_q;
`endif

  logic [NB_OPCODE-1:0] rx_opcode;
  logic [NB_OPCODE-1:0] hi_opcode;

  assign rx_opcode = i_rx_data[NB_BYTE-1 -: NB_OPCODE];
  assign hi_opcode = hi_q[NB_BYTE-1 -: NB_OPCODE];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_WAIT_HI;
      addr_q    <= '0;
      hi_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      cpu_en_q  <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
`ifdef BIP_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      // NOTE: defaulting the strobe low here is what limits each write to one cycle.
      wr_en_q <= 1'b0;
      unique case (state_q)
        ST_WAIT_HI: begin
          if (i_rx_done) begin
`ifdef BIP_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ i_rx_data;
`endif
            if (opcode_valid(rx_opcode)) begin
              hi_q    <= i_rx_data;
              state_q <= ST_WAIT_LO;
            end else begin
              error_q <= 1'b1;
              code_q  <= ERR_OPCODE;
              state_q <= ST_ERROR;
            end
          end
        end
        ST_WAIT_LO: begin
          if (i_rx_done) begin
`ifdef BIP_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ i_rx_data;
`endif
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= {hi_q, i_rx_data};
            if (hi_opcode == OP_HLT) begin
`ifdef BIP_LOADER_CHECKSUM_EN
              state_q  <= ST_CHECK;
`else
              done_q   <= 1'b1;
              cpu_en_q <= 1'b1;
              state_q  <= ST_DONE;
`endif
            end else if (addr_q == LAST_ADDR) begin
              // Last word is still stored; the counter stays put so nothing wraps to 0.
              error_q <= 1'b1;
              code_q  <= ERR_OVERFLOW;
              state_q <= ST_ERROR;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_WAIT_HI;
            end
          end
        end
`ifdef BIP_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (i_rx_done) begin
            if (i_rx_data == csum_q) begin
              done_q   <= 1'b1;
              cpu_en_q <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              error_q <= 1'b1;
              code_q  <= ERR_CHECKSUM;
              state_q <= ST_ERROR;
            end
          end
        end
`endif
        ST_DONE, ST_ERROR: begin
          // Restart takes priority over any byte arriving in the same cycle.
          if (i_restart) begin
            state_q  <= ST_WAIT_HI;
            addr_q   <= '0;
            done_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= ERR_NONE;
`ifdef BIP_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        default: state_q <= ST_WAIT_HI;
      endcase
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_cpu_enable = cpu_en_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_error_code = code_q;

endmodule

// File: tb/tb_bip_prog_loader.sv
// Self-checking bench for bip_prog_loader: directed scenarios plus random programs, checked against
// a byte-stream reference model. Honors BIP_LOADER_CHECKSUM_EN when the design is built with it.
`timescale 1ns/1ps
module tb_bip_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        restart;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_en;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  bip_prog_loader dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_restart    (restart),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_cpu_enable (cpu_en),
    .o_done       (done),
    .o_error      (err),
    .o_error_code (err_code)
  );

  int checks = 0;
  int errors = 0;

  logic [26:0] obs_q[$];
  logic [26:0] exp_q[$];
  bit          done_at_wr_q[$];
  logic [7:0]  stim_q[$];
  bit          exp_done;
  bit          exp_err;
  logic [1:0]  exp_code;
  int          pulse_viol = 0;
  logic        prev_wr = 1'b0;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      obs_q.push_back({wr_addr, wr_data});
      done_at_wr_q.push_back(done);
    end
    if (wr_en && prev_wr) pulse_viol++;
    prev_wr = wr_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    stim_q.push_back(b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  function automatic logic [7:0] stream_xor();
    logic [7:0] x = 8'h00;
    foreach (stim_q[i]) x ^= stim_q[i];
    return x;
  endfunction

  // Appends the checksum byte when the feature is built in; no-op otherwise.
  task automatic send_cs();
`ifdef BIP_LOADER_CHECKSUM_EN
    send(stream_xor());
`endif
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic new_round();
    stim_q.delete();
    obs_q.delete();
    done_at_wr_q.delete();
  endtask

  // Reference: walk the byte stream as (hi,lo) pairs and derive writes and final status.
  task automatic model_run();
    int         i = 0;
    int         addr = 0;
    bit         fin = 0;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] x = 8'h00;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_code = 2'b00;
    while (!fin && i < stim_q.size()) begin
      hi = stim_q[i];
      if (hi[7:3] > 5'd7) begin
        exp_err = 1; exp_code = 2'b01; fin = 1;
      end else if (i + 1 < stim_q.size()) begin
        lo = stim_q[i+1];
        x  = x ^ hi ^ lo;
        exp_q.push_back({11'(addr), hi, lo});
        if (hi[7:3] == 5'd0) begin
`ifdef BIP_LOADER_CHECKSUM_EN
          if (i + 2 < stim_q.size()) begin
            if (stim_q[i+2] == x) exp_done = 1;
            else begin exp_err = 1; exp_code = 2'b11; end
          end
`else
          exp_done = 1;
`endif
          fin = 1;
        end else if (addr == 2047) begin
          exp_err = 1; exp_code = 2'b10; fin = 1;
        end
        addr++;
        i += 2;
      end else begin
        fin = 1;
      end
    end
  endtask

  task automatic verify(input string tag);
    int n;
    idle(3);
    model_run();
    check({tag, ".nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      check($sformatf("%s.wr%0d", tag, k), 32'(obs_q[k]), 32'(exp_q[k]));
    check({tag, ".done"},   32'(done),     32'(exp_done));
    check({tag, ".cpu_en"}, 32'(cpu_en),   32'(exp_done));
    check({tag, ".error"},  32'(err),      32'(exp_err));
    check({tag, ".code"},   32'(err_code), 32'(exp_code));
    check({tag, ".pulse"},  32'(pulse_viol), 32'd0);
    if (exp_done && n > 0 && n == exp_q.size()) begin
`ifdef BIP_LOADER_CHECKSUM_EN
      check({tag, ".done_at_hlt"}, 32'(done_at_wr_q[n-1]), 32'd0);
`else
      check({tag, ".done_at_hlt"}, 32'(done_at_wr_q[n-1]), 32'd1);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.wr_en",   32'(wr_en),    32'd0);
    check("rst.wr_addr", 32'(wr_addr),  32'd0);
    check("rst.wr_data", 32'(wr_data),  32'd0);
    check("rst.cpu_en",  32'(cpu_en),   32'd0);
    check("rst.done",    32'(done),     32'd0);
    check("rst.error",   32'(err),      32'd0);
    check("rst.code",    32'(err_code), 32'd0);
    rst = 1'b0;
    idle(1);

    // Three-word program ending in HLT, followed by stray bytes.
    new_round();
    send(8'h18); send(8'h05); idle(1); send(8'h28); send(8'h03); send(8'h00); send(8'h00);
    send_cs();
    idle(2);
    send(8'h11); send(8'h22);
    verify("prog3");
    check("prog3.first", 32'(obs_q.size() > 0 ? obs_q[0] : 27'h0), 32'({11'd0, 16'h1805}));

    // Invalid opcode, then a fresh one-word program after restart.
    pulse_restart();
    new_round();
    send(8'h40); send(8'h00);
    verify("badop");
    check("badop.code_const", 32'(err_code), 32'h1);
    pulse_restart();
    new_round();
    send(8'h00); send(8'h00); send_cs();
    verify("reload");

    // Restart coincident with a byte in DONE: byte must be dropped.
    new_round();
    rx_data = 8'h18; rx_done = 1'b1; restart = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0; restart = 1'b0;
    idle(2);
    check("coinc.done",    32'(done), 32'd0);
    check("coinc.nwrites", 32'(obs_q.size()), 32'd0);
    send(8'h00); send(8'h00); send_cs();
    verify("coinc");

    // Reset while a high byte is pending.
    pulse_restart();
    send(8'h18);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    new_round();
    send(8'h00); send(8'h00); send_cs();
    verify("midrst");

    // Fill the whole program memory without HLT.
    pulse_restart();
    new_round();
    for (int w = 0; w < 2048; w++) begin
      send(8'h08); send(8'h01);
    end
    idle(2);
    send(8'h00); send(8'h00);
    verify("ovf");
    check("ovf.last_addr", 32'(obs_q.size() > 0 ? obs_q[obs_q.size()-1][26:16] : 11'd0), 32'd2047);

`ifdef BIP_LOADER_CHECKSUM_EN
    pulse_restart();
    new_round();
    send(8'h18); send(8'h05); send(8'h00); send(8'h00);
    idle(2);
    check("cs.pending_done", 32'(done), 32'd0);
    send(8'h1D);
    verify("cs_ok");
    pulse_restart();
    new_round();
    send(8'h18); send(8'h05); send(8'h00); send(8'h00); send(8'h1C);
    verify("cs_bad");
`endif

    // Random programs with random byte spacing and occasional invalid opcodes.
    for (int r = 0; r < 20; r++) begin
      int nw;
      pulse_restart();
      new_round();
      nw = int'($urandom_range(1, 20));
      for (int w = 0; w < nw; w++) begin
        logic [4:0]  op;
        logic [10:0] operand;
        if (w == nw - 1)                 op = 5'd0;
        else if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(8, 31));
        else                             op = 5'($urandom_range(1, 7));
        operand = 11'($urandom);
        send({op, operand[10:8]});
        idle(int'($urandom_range(0, 2)));
        send(operand[7:0]);
        idle(int'($urandom_range(0, 2)));
      end
`ifdef BIP_LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) send(stream_xor() ^ 8'h01);
      else                           send(stream_xor());
`endif
      verify($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_prog_loader.md
Name: bip_prog_loader

Overview:
- Writer side of the BIP instruction path: receives a program as a byte stream from the UART receiver and assembles 16-bit instruction words.
- Validates each opcode and writes the word into program memory, holding the CPU in reset/stall until a HLT word has been stored.
- Sits between uart_rx and the program RAM; its o_cpu_enable gates the fetch/decode path.

Parameters:
- NB_BYTE, 8, UART byte width
- NB_OPCODE, 5, opcode field width
- NB_OPERAND, 11, operand field width
- NB_INSTR, 16, instruction word width (NB_OPCODE+NB_OPERAND)
- NB_ADDR, 11, program memory address width
- PROG_DEPTH, 2048, number of program memory words

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_done  in  1  one-cycle pulse, i_rx_data valid
- i_restart  in  1  one-cycle pulse, return from DONE/ERROR to load a new program
- o_wr_en  out  1  program memory write strobe
- o_wr_addr  out  NB_ADDR  program memory write address
- o_wr_data  out  NB_INSTR  instruction word
- o_cpu_enable  out  1  high only in DONE
- o_done  out  1  program loaded successfully (level)
- o_error  out  1  load aborted (level)
- o_error_code  out  2  00 none, 01 invalid opcode, 10 overflow, 11 checksum

Behaviour:
- Interface: one clock i_clock; reset i_reset is synchronous and active-high.
- Reset values:
  - state WAIT_HI; address counter 0
  - o_wr_en 0, o_wr_addr 0, o_wr_data 0
  - o_cpu_enable 0, o_done 0, o_error 0, o_error_code 00
- Word format: first byte is high byte. opcode = hi[7:3]; operand = {hi[2:0], lo}. Valid opcodes are 0..7 (HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI).
- States: WAIT_HI, WAIT_LO, DONE, ERROR; plus CHECK when the optional feature is compiled in.
- WAIT_HI + i_rx_done:
  - latch the byte and go to WAIT_LO.
  - Opcode is checked here: if hi[7:3] > 7, go to ERROR with code 01.
- WAIT_LO + i_rx_done:
  - register o_wr_data = {hi, lo} and o_wr_addr = counter; pulse o_wr_en for exactly 1 cycle, the cycle after the low byte's i_rx_done.
  - If opcode == HLT, go to DONE.
  - Else if counter == PROG_DEPTH-1, go to ERROR with code 10. The word is still written; the counter does not wrap.
  - Else increment the counter and return to WAIT_HI.
- DONE:
  - o_done = 1 and o_cpu_enable = 1, both registered. They rise on the same cycle as the HLT write pulse.
  - i_rx_done is ignored.
- ERROR:
  - o_error = 1; o_error_code holds its value; o_cpu_enable = 0.
  - i_rx_done is ignored; no further writes.
- i_restart (DONE or ERROR only):
  - next state WAIT_HI; counter, flags and code cleared; memory contents untouched.
  - Ignored in WAIT_HI/WAIT_LO.
  - If i_restart and i_rx_done arrive in the same cycle, the restart wins and the byte is dropped.
- i_reset mid-load: the partial high byte is discarded; loading restarts at address 0.
- Throughput: any byte spacing of 1 cycle or more is sustained; no byte is dropped in WAIT_HI/WAIT_LO.

Optional Feature:
- Macro: BIP_LOADER_CHECKSUM_EN
- Defined:
  - A running XOR of every received byte is kept; it is cleared by reset/restart.
  - After the HLT write, go to CHECK instead of DONE.
  - The next i_rx_done byte is compared with the accumulated XOR: equal goes to DONE; different goes to ERROR with code 11.
  - o_done/o_cpu_enable are delayed until the check passes.
- Undefined: no CHECK state, no accumulator; HLT goes straight to DONE; code 11 is never produced.

Decomposition:
- Shared package bip_pkg:
  - opcode constants HLT..SUBI (5-bit)
  - field widths NB_OPCODE/NB_OPERAND/NB_INSTR
  - state encoding
  - error-code constants
- The same opcode constants are used by the decoder and the loader.
- No sub-module. FSM, address counter and XOR accumulator stay in one module.

Test Plan:
- Bytes 0x18,0x05 / 0x28,0x03 / 0x00,0x00 -> writes 0x1805@0, 0x2803@1, 0x0000@2; each o_wr_en is 1 cycle; o_done=o_cpu_enable=1 with the third write; later bytes cause no writes.
- Bytes 0x40,0x00 -> no write; o_error=1, code 01, o_cpu_enable=0; i_restart then 0x00,0x00 -> write 0x0000@0, o_done=1.
- 2048 words of 0x0801 (STO 1) -> last write @2047, then o_error code 10; no write to address 0 afterwards.
- Reset asserted after 0x18, then 0x00,0x00 -> single write 0x0000@0, o_done=1.
- i_restart coincident with i_rx_done in DONE -> byte dropped, state WAIT_HI, no write.
- With BIP_LOADER_CHECKSUM_EN: 0x18,0x05,0x00,0x00,0x1D -> o_done=1 after the 5th byte; checksum 0x1C -> o_error code 11.
